// File: rtl/sample_data_collector.sv
// Single-channel capture buffer: records i_data strobes between start/stop
// commands into a block-RAM style buffer that can be read back at any time.
module sample_data_collector #(
  parameter int G_DATA_WIDTH = 8,
  parameter int G_ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [G_DATA_WIDTH-1:0] i_data,
  input  logic                    i_data_valid,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic                    i_clear,
  input  logic [G_ADDR_WIDTH-1:0] i_rd_addr,
  output logic [G_DATA_WIDTH-1:0] o_rd_data,
  output logic                    o_collecting,
  output logic [G_ADDR_WIDTH:0]   o_nb_data,
  output logic                    o_full,
  output logic                    o_overflow
);

  localparam int DEPTH = 2 ** G_ADDR_WIDTH;
  localparam logic [G_ADDR_WIDTH:0] FULL_CNT = {1'b1, {G_ADDR_WIDTH{1'b0}}};
  localparam logic [G_ADDR_WIDTH:0] ONE_CNT  = {{G_ADDR_WIDTH{1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [G_ADDR_WIDTH:0]   nb_q, nb_d;
  logic                    ovf_q, ovf_d;
  logic [G_DATA_WIDTH-1:0] rd_data_q;
  logic                    capture;
  logic                    wr_en;
  logic [G_ADDR_WIDTH-1:0] wr_addr;

  logic [G_DATA_WIDTH-1:0] mem [DEPTH];

  // Capture looks at the registered state, so the i_stop cycle still stores.
  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    capture = (state_q == ST_COLLECT) && i_data_valid;

    if (i_clear) begin
      state_d = ST_IDLE;
      nb_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      if (capture) begin
        if (nb_q != FULL_CNT) begin
          wr_en = 1'b1;
          nb_d  = nb_q + ONE_CNT;
        end else begin
          ovf_d = 1'b1;
        end
      end

      if (state_q == ST_COLLECT) begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end
      end else if (i_start) begin
        // Start clears the counters even when a simultaneous stop keeps us idle.
        nb_d  = '0;
        ovf_d = 1'b0;
        if (!i_stop) begin
          state_d = ST_COLLECT;
        end
      end
    end
  end

  assign wr_addr = nb_q[G_ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      nb_q      <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      nb_q      <= nb_d;
      ovf_q     <= ovf_d;
      rd_data_q <= mem[i_rd_addr];
    end
  end

  // Buffer storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= i_data;
    end
  end

  assign o_rd_data    = rd_data_q;
  assign o_collecting = (state_q == ST_COLLECT);
  assign o_nb_data    = nb_q;
  assign o_full       = (nb_q == FULL_CNT);
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_sample_data_collector.sv
// Scoreboard bench for sample_data_collector: directed scenarios followed by
// random traffic, checked against a queue-based acquisition model.
module tb_sample_data_collector;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic          i_start;
  logic          i_stop;
  logic          i_clear;
  logic [AW-1:0] i_rd_addr;
  logic [DW-1:0] o_rd_data;
  logic          o_collecting;
  logic [AW:0]   o_nb_data;
  logic          o_full;
  logic          o_overflow;

  sample_data_collector #(
    .G_DATA_WIDTH(DW),
    .G_ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_data      (i_data),
    .i_data_valid(i_data_valid),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_clear     (i_clear),
    .i_rd_addr   (i_rd_addr),
    .o_rd_data   (o_rd_data),
    .o_collecting(o_collecting),
    .o_nb_data   (o_nb_data),
    .o_full      (o_full),
    .o_overflow  (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          coll;
    int            nb;
    logic          full;
    logic          ovf;
    logic          rd_chk;
    logic [DW-1:0] rd;
    int            addr;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: acquisition as a list of stored samples plus a word image
  logic          m_coll;
  logic          m_ovf;
  logic [DW-1:0] m_samples[$];
  logic [DW-1:0] m_mem[DEPTH];
  logic          m_known[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_coll = 1'b0;
    m_ovf  = 1'b0;
    m_samples.delete();
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  endtask

  task automatic cycle(input logic start, input logic stop, input logic clear,
                       input logic valid, input logic [DW-1:0] data,
                       input int addr);
    exp_t e;
    i_start      = start;
    i_stop       = stop;
    i_clear      = clear;
    i_data_valid = valid;
    i_data       = data;
    i_rd_addr    = addr[AW-1:0];

    e.addr   = addr;
    e.rd_chk = m_known[addr];
    e.rd     = m_mem[addr];

    if (clear) begin
      m_coll = 1'b0;
      m_ovf  = 1'b0;
      m_samples.delete();
    end else if (m_coll) begin
      if (valid) begin
        if (m_samples.size() < DEPTH) begin
          m_mem[m_samples.size()]   = data;
          m_known[m_samples.size()] = 1'b1;
          m_samples.push_back(data);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (stop) m_coll = 1'b0;
    end else if (start) begin
      m_samples.delete();
      m_ovf  = 1'b0;
      m_coll = !stop;
    end

    e.coll = m_coll;
    e.nb   = m_samples.size();
    e.full = (m_samples.size() == DEPTH);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 10),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 65),
            DW'($urandom), int'($urandom_range(0, DEPTH - 1)));
    end
  endtask

  // Monitor: every edge the driver scheduled has one expectation waiting.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("collecting", 32'(o_collecting), 32'(e.coll));
        chk("nb_data", 32'(o_nb_data), 32'(e.nb));
        chk("full", 32'(o_full), 32'(e.full));
        chk("overflow", 32'(o_overflow), 32'(e.ovf));
        if (e.rd_chk) chk($sformatf("rd_data@%0d", e.addr), 32'(o_rd_data), 32'(e.rd));
      end
    end
  end

  task automatic checkOutput(input string tag);
    chk({tag, "_rd_data"}, 32'(o_rd_data), 32'h0);
    chk({tag, "_collecting"}, 32'(o_collecting), 32'h0);
    chk({tag, "_nb_data"}, 32'(o_nb_data), 32'h0);
    chk({tag, "_full"}, 32'(o_full), 32'h0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'h0);
  endtask

  initial begin
    logic [DW-1:0] seq4[4];
    logic [DW-1:0] seq6[6];
    seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq6 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    rst_n = 1'b0;
    i_start = 0; i_stop = 0; i_clear = 0; i_data_valid = 0;
    i_data = '0; i_rd_addr = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Strobes before start, a 4-sample acquisition, strobe after stop, readback
    cycle(0, 0, 0, 1, 8'hAA, 0);
    cycle(0, 0, 0, 1, 8'hBB, 0);
    cycle(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, seq4[i], 0);
    cycle(0, 1, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 1, 8'h99, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 8'h00, i);

    // Overflow: six samples into a four-deep buffer
    cycle(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, seq6[i], 0);
    cycle(0, 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 8'h00, i);

    // Clear mid-acquisition, then restart at address 0
    cycle(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'hC0 + DW'(i), 0);
    cycle(0, 0, 1, 1, 8'hEE, 0);
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 1, 8'h77, 0);
    cycle(0, 1, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 0, 8'h00, 0);

    // Stop with a valid sample, then start+stop together while idle
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 1, 8'h01, 0);
    cycle(0, 1, 0, 1, 8'h5A, 0);
    cycle(0, 0, 0, 0, 8'h00, 1);
    cycle(1, 1, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 1, 8'h33, 0);

    // Asynchronous reset between edges while collecting
    cycle(1, 0, 0, 0, 8'h00, 0);
    cycle(0, 0, 0, 1, 8'h42, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(2000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
